// File: rtl/stream_demux.sv
// Packet-aware 1-to-N stream router. Each packet goes whole to the port named on its first beat,
// through a one-entry registered slice per output; packets to missing ports are dropped and counted.
module stream_demux #(
  parameter int DATA_WIDTH = 32,
  parameter int OUTPUT_NUM = 2,
  parameter int ADDR_WIDTH = $clog2(OUTPUT_NUM),
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [ADDR_WIDTH-1:0] dest_i,
  input  logic                  last_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o [OUTPUT_NUM],
  output logic [OUTPUT_NUM-1:0] last_o,
  output logic [OUTPUT_NUM-1:0] valid_o,
  input  logic [OUTPUT_NUM-1:0] ready_i,
  output logic                  drop_pulse_o,
  output logic [CNT_WIDTH-1:0]  drop_cnt_o
);

  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] lock_q;
  logic [DATA_WIDTH-1:0] dataSlice_q [OUTPUT_NUM];
  logic [OUTPUT_NUM-1:0] lastSlice_q;
  logic [OUTPUT_NUM-1:0] validSlice_q;
  logic                  dropPulse_q;
  logic [CNT_WIDTH-1:0]  dropCnt_q;

  logic [ADDR_WIDTH-1:0] target;
  logic                  destOk;
  logic                  targetBusy;
  logic                  accept;
  logic                  routeBeat;
  logic                  dropFirst;

  // Only the target port's own slice can stall the input, so a stalled port never blocks the others.
  always_comb begin
    target     = (state_q == IDLE) ? dest_i : lock_q;
    destOk     = (32'(dest_i) < OUTPUT_NUM);
    targetBusy = 1'b0;
    for (int k = 0; k < OUTPUT_NUM; k++) begin
      if (target == ADDR_WIDTH'(k)) begin
        targetBusy = validSlice_q[k] & ~ready_i[k];
      end
    end
    if ((state_q == DROP) || ((state_q == IDLE) && !destOk)) begin
      ready_o = ARESETn;
    end else begin
      ready_o = ARESETn & ~targetBusy;
    end
    accept    = valid_i & ready_o;
    routeBeat = accept & ((state_q == ROUTE) | ((state_q == IDLE) & destOk));
    dropFirst = accept & (state_q == IDLE) & ~destOk;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= IDLE;
      lock_q       <= '0;
      lastSlice_q  <= '0;
      validSlice_q <= '0;
      dropPulse_q  <= 1'b0;
      dropCnt_q    <= '0;
      for (int k = 0; k < OUTPUT_NUM; k++) begin
        dataSlice_q[k] <= '0;
      end
    end else begin
      dropPulse_q <= dropFirst;
      if (dropFirst && (dropCnt_q != '1)) begin
        dropCnt_q <= dropCnt_q + CNT_WIDTH'(1);
      end

      if (accept) begin
        case (state_q)
          IDLE: begin
            if (destOk) begin
              lock_q <= dest_i;
            end
            if (!last_i) begin
              state_q <= destOk ? ROUTE : DROP;
            end
          end
          ROUTE, DROP: begin
            if (last_i) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end

      // A load wins over a drain so a slice read and refilled in one cycle stays full.
      for (int k = 0; k < OUTPUT_NUM; k++) begin
        if (routeBeat && (target == ADDR_WIDTH'(k))) begin
          dataSlice_q[k]  <= data_i;
          lastSlice_q[k]  <= last_i;
          validSlice_q[k] <= 1'b1;
        end else if (validSlice_q[k] && ready_i[k]) begin
          validSlice_q[k] <= 1'b0;
        end
      end
    end
  end

  assign data_o       = dataSlice_q;
  assign last_o       = lastSlice_q;
  assign valid_o      = validSlice_q;
  assign drop_pulse_o = dropPulse_q;
  assign drop_cnt_o   = dropCnt_q;

endmodule
